fetch_unit: RTL and testbench

Parametrised instruction fetch stage sitting between the controller, the i-cache and decode. It holds the architectural fetch PC and issues one i-cache request at a time with a valid/ready handshake. Returned instructions are buffered, tagged with their PC, in a circular queue of configurable depth. A controller redirect flushes the queue and discards any in-flight response.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit_queue.sv | 46 ++++
 rtl/fetch_unit.sv | 78 +++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared data widths, fetch FSM states and JAL decode helpers
package fetch_pkg;
  localparam int XLEN_DEF = 32;
  localparam int ILEN_DEF = 32;
  localparam logic [6:0] OPCODE_JAL = 7'b1101111;
  typedef enum logic [1:0] {REQ, WAIT, DROP} fetch_state_e;
  // J-type immediate as a 21-bit two's complement byte offset
  function automatic logic [20:0] jal_imm(input logic [31:0] inst);
    return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: controller redirect, i-cache request/response and decode handshake of the fetch stage
interface fetch_unit_if #(
  parameter int XLEN = fetch_pkg::XLEN_DEF,
  parameter int ILEN = fetch_pkg::ILEN_DEF
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            icache_req_valid;
  logic            icache_req_ready;
  logic [XLEN-1:0] icache_req_addr;
  logic            icache_resp_valid;
  logic [ILEN-1:0] icache_resp_inst;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst_out;
  logic [XLEN-1:0] inst_pc;
  logic            inst_pred_taken;
  modport master (
    input  redirect_valid, redirect_pc, icache_req_ready, icache_resp_valid, icache_resp_inst, inst_ready,
    output icache_req_valid, icache_req_addr, inst_valid, inst_out, inst_pc, inst_pred_taken
  );
  modport slave (
    output redirect_valid, redirect_pc, icache_req_ready, icache_resp_valid, icache_resp_inst, inst_ready,
    input  icache_req_valid, icache_req_addr, inst_valid, inst_out, inst_pc, inst_pred_taken
  );
endinterface

// File: rtl/fetch_unit_queue.sv
// fetch_queue: circular FIFO of {inst, pc, pred} entries with synchronous flush
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;
  assign do_push = push && !flush;
  assign do_pop  = pop && count_q != '0;
  // pointer/occupancy update; flush wins over any push or pop
  always_comb begin
    wr_d    = flush ? '0 : wr_q + PW'(do_push);
    rd_d    = flush ? '0 : rd_q + PW'(do_pop);
    count_d = flush ? '0 : count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  // entry storage, written at the tail
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
  assign rdata = count_q != '0 ? mem_q[rd_q] : '0;
  assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC and request FSM feeding a PC-tagged instruction queue
// Optional JAL target prediction is enabled by defining FETCH_JAL_PREDICT_EN.
module fetch_unit import fetch_pkg::*; #(
  parameter int              XLEN        = XLEN_DEF,
  parameter int              ILEN        = ILEN_DEF,
  parameter int              QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam int EW = ILEN + XLEN + 1;
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d, next_pc, redir_pc;
  logic            run_q, run_d, hs, rsp, redir, is_jal, push, flush;
  logic [CW-1:0]   count;
  logic [EW-1:0]   head;
  logic [20:0]     jimm;
  assign redir    = bus.redirect_valid;
  assign rsp      = bus.icache_resp_valid;
  assign hs       = bus.icache_req_valid && bus.icache_req_ready;
  assign redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign jimm     = jal_imm(bus.icache_resp_inst[31:0]);
`ifdef FETCH_JAL_PREDICT_EN
  assign is_jal = bus.icache_resp_inst[6:0] == OPCODE_JAL;
`else
  assign is_jal = 1'b0;
`endif
  assign next_pc = req_pc_q + (is_jal ? {{(XLEN-21){jimm[20]}}, jimm} : XLEN'(4));
  // state register plus PC bookkeeping; run_q keeps requests off until reset is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      run_q    <= run_d;
    end
  end
  // next state: a redirect turns any in-flight request into a drop
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      REQ:     state_d = hs ? (redir ? DROP : WAIT) : REQ;
      WAIT:    state_d = rsp ? REQ : (redir ? DROP : WAIT);
      DROP:    state_d = rsp ? REQ : DROP;
      default: state_d = REQ;
    endcase
  end
  // datapath controls: redirect flushes and retargets, a kept response advances the PC
  always_comb begin
    run_d    = 1'b1;
    flush    = redir;
    push     = state_q == WAIT && rsp && !redir;
    req_pc_d = (state_q == REQ && hs) ? pc_q : req_pc_q;
    pc_d     = redir ? redir_pc : push ? next_pc : pc_q;
  end
  fetch_queue #(.DEPTH(QUEUE_DEPTH), .W(EW)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (bus.inst_ready),
    .wdata ({bus.icache_resp_inst, req_pc_q, is_jal}),
    .rdata (head),
    .count (count)
  );
  assign bus.icache_req_valid = run_q && state_q == REQ && count < CW'(QUEUE_DEPTH);
  assign bus.icache_req_addr  = pc_q;
  assign bus.inst_valid       = count != '0;
  assign {bus.inst_out, bus.inst_pc, bus.inst_pred_taken} = head;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, directed corner sequences and a randomized run against a queue-level model
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h100;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fetch_unit_if #(.XLEN(32), .ILEN(32)) bus();
  fetch_unit #(.XLEN(32), .ILEN(32), .QUEUE_DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  typedef struct {
    logic rdy, rsp, irdy, rdr;
    logic [31:0] rinst, rpc;
    logic erv;
    logic [31:0] eaddr;
    logic eiv;
    logic [31:0] eipc;
  } vec_t;
  typedef struct {
    logic [31:0] inst, pc;
    logic pred;
  } ent_t;
  vec_t tv[16];
  ent_t mq[$];
  int n_cmp = 0, n_err = 0, nhs = 0, cd = 0;
  bit use_model = 0, m_busy, m_drop, m_run, rsp_jal;
  logic [31:0] m_pc, m_out_pc, rsp_off, auto_inst = 32'h13;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic m_reset();
    mq.delete();
    m_pc = RPC; m_busy = 0; m_drop = 0; m_run = 0;
  endtask
  task automatic m_step();
    bit erv, hs;
    ent_t e;
    logic [31:0] tgt;
    erv = m_run && !m_busy && mq.size() < D;
    hs = erv && bus.icache_req_ready;
    m_run = 1;
    if (bus.redirect_valid) begin
      mq.delete();
      m_pc = {bus.redirect_pc[31:2], 2'b00};
      if (bus.icache_resp_valid) m_busy = 0;
      if (hs) begin m_busy = 1; m_drop = 1; end
      else if (m_busy) m_drop = 1;
    end else begin
      if (bus.inst_ready && mq.size() > 0) mq.delete(0);
      if (hs) begin m_busy = 1; m_drop = 0; m_out_pc = m_pc; end
      if (bus.icache_resp_valid) begin
        m_busy = 0;
        if (!m_drop) begin
          e.inst = bus.icache_resp_inst; e.pc = m_out_pc; e.pred = 0; tgt = m_out_pc + 4;
`ifdef FETCH_JAL_PREDICT_EN
          if (rsp_jal) begin e.pred = 1; tgt = m_out_pc + rsp_off; end
`endif
          mq.push_back(e);
          m_pc = tgt;
        end
        m_drop = 0;
      end
    end
  endtask
  task automatic m_check();
    chk("m_req_valid", 32'(bus.icache_req_valid), 32'(m_run && !m_busy && mq.size() < D));
    chk("m_req_addr", bus.icache_req_addr, m_pc);
    chk("m_inst_valid", 32'(bus.inst_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("m_inst_out", bus.inst_out, mq[0].inst);
      chk("m_inst_pc", bus.inst_pc, mq[0].pc);
      chk("m_pred", 32'(bus.inst_pred_taken), 32'(mq[0].pred));
    end
  endtask
  task automatic tick();
    bit hs;
    int o;
    logic [20:0] im;
    hs = bus.icache_req_valid && bus.icache_req_ready;
    if (use_model) m_step();
    @(posedge clk); #1;
    if (hs) nhs++;
    if (use_model) m_check();
    bus.icache_resp_valid = 0;
    if (hs) cd = use_model ? int'($urandom_range(1, 3)) : 1;
    if (cd != 0) begin
      cd--;
      if (cd == 0) begin
        bus.icache_resp_valid = 1;
        if (!use_model) begin
          bus.icache_resp_inst = auto_inst;
        end else if ($urandom_range(0, 4) == 0) begin
          o = (int'($urandom_range(0, 511)) - 256) * 4;
          rsp_off = 32'(o); rsp_jal = 1; im = rsp_off[20:0];
          bus.icache_resp_inst = {im[20], im[10:1], im[11], im[19:12], 5'd1, 7'b1101111};
        end else begin
          rsp_jal = 0;
          bus.icache_resp_inst = {$urandom()} & 32'hFFFF_FF80 | 32'h13;
        end
      end
    end
  endtask
  task automatic do_reset();
    rst_n = 0;
    bus.redirect_valid = 0; bus.redirect_pc = 0; bus.icache_req_ready = 0;
    bus.icache_resp_valid = 0; bus.icache_resp_inst = 0; bus.inst_ready = 0;
    cd = 0; nhs = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    tv[0]  = '{1, 0, 1, 0, 32'h0,  32'h0,        1, 32'h100,      0, 32'h0};
    tv[1]  = '{1, 0, 1, 0, 32'h0,  32'h0,        0, 32'h100,      0, 32'h0};
    tv[2]  = '{1, 1, 1, 0, 32'h13, 32'h0,        1, 32'h104,      1, 32'h100};
    tv[3]  = '{1, 0, 1, 0, 32'h0,  32'h0,        0, 32'h104,      0, 32'h0};
    tv[4]  = '{1, 1, 1, 0, 32'h13, 32'h0,        1, 32'h108,      1, 32'h104};
    tv[5]  = '{1, 0, 1, 0, 32'h0,  32'h0,        0, 32'h108,      0, 32'h0};
    tv[6]  = '{1, 0, 1, 1, 32'h0,  32'h203,      0, 32'h200,      0, 32'h0};
    tv[7]  = '{1, 1, 1, 0, 32'h13, 32'h0,        1, 32'h200,      0, 32'h0};
    tv[8]  = '{1, 0, 1, 0, 32'h0,  32'h0,        0, 32'h200,      0, 32'h0};
    tv[9]  = '{1, 1, 1, 1, 32'h13, 32'h300,      1, 32'h300,      0, 32'h0};
    tv[10] = '{0, 0, 1, 0, 32'h0,  32'h0,        1, 32'h300,      0, 32'h0};
    tv[11] = '{1, 0, 1, 1, 32'h0,  32'hFFFFFFFC, 0, 32'hFFFFFFFC, 0, 32'h0};
    tv[12] = '{0, 1, 1, 0, 32'h13, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0};
    tv[13] = '{1, 0, 1, 0, 32'h0,  32'h0,        0, 32'hFFFFFFFC, 0, 32'h0};
    tv[14] = '{0, 1, 0, 0, 32'h13, 32'h0,        1, 32'h0,        1, 32'hFFFFFFFC};
    tv[15] = '{0, 0, 1, 0, 32'h0,  32'h0,        1, 32'h0,        0, 32'h0};
    do_reset();
    chk("rst_req_valid", 32'(bus.icache_req_valid), 0);
    chk("rst_req_addr", bus.icache_req_addr, RPC);
    chk("rst_inst_valid", 32'(bus.inst_valid), 0);
    chk("rst_inst_out", bus.inst_out, 0);
    chk("rst_inst_pc", bus.inst_pc, 0);
    chk("rst_pred", 32'(bus.inst_pred_taken), 0);
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      bus.icache_req_ready = tv[i].rdy; bus.icache_resp_valid = tv[i].rsp; bus.inst_ready = tv[i].irdy;
      bus.redirect_valid = tv[i].rdr; bus.icache_resp_inst = tv[i].rinst; bus.redirect_pc = tv[i].rpc;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_req_valid", i), 32'(bus.icache_req_valid), 32'(tv[i].erv));
      chk($sformatf("vec%0d_req_addr", i), bus.icache_req_addr, tv[i].eaddr);
      chk($sformatf("vec%0d_inst_valid", i), 32'(bus.inst_valid), 32'(tv[i].eiv));
      if (tv[i].eiv) begin
        chk($sformatf("vec%0d_inst_pc", i), bus.inst_pc, tv[i].eipc);
        chk($sformatf("vec%0d_inst_out", i), bus.inst_out, 32'h13);
      end
    end
    do_reset();
    rst_n = 1;
    bus.icache_req_ready = 1;
    repeat (30) tick();
    chk("bp_requests", nhs, 4);
    chk("bp_req_valid", 32'(bus.icache_req_valid), 0);
    chk("bp_head_pc", bus.inst_pc, 32'h100);
    bus.inst_ready = 1;
    tick();
    bus.inst_ready = 0;
    repeat (20) tick();
    chk("bp_requests_after_pop", nhs, 5);
    chk("bp_head_pc_after_pop", bus.inst_pc, 32'h104);
    chk("bp_inst_valid", 32'(bus.inst_valid), 1);
    do_reset();
    rst_n = 1;
    bus.icache_req_ready = 1;
    repeat (6) tick();
    chk("ar_pre_inst_valid", 32'(bus.inst_valid), 1);
    chk("ar_pre_req_valid", 32'(bus.icache_req_valid), 0);
    #2;
    rst_n = 0; bus.icache_resp_valid = 0; cd = 0;
    #1;
    chk("ar_req_valid", 32'(bus.icache_req_valid), 0);
    chk("ar_inst_valid", 32'(bus.inst_valid), 0);
    chk("ar_req_addr", bus.icache_req_addr, RPC);
    @(posedge clk); #1;
    rst_n = 1;
    tick();
    chk("ar_restart_valid", 32'(bus.icache_req_valid), 1);
    chk("ar_restart_addr", bus.icache_req_addr, RPC);
    tick(); tick();
    chk("ar_restart_inst_pc", bus.inst_pc, RPC);
    chk("ar_restart_next", bus.icache_req_addr, 32'h104);
    do_reset();
    rst_n = 1;
    auto_inst = 32'h0100006F;
    bus.icache_req_ready = 1;
    repeat (3) tick();
    chk("jal_inst_out", bus.inst_out, 32'h0100006F);
    chk("jal_inst_pc", bus.inst_pc, 32'h100);
`ifdef FETCH_JAL_PREDICT_EN
    chk("jal_next_addr", bus.icache_req_addr, 32'h110);
    chk("jal_pred", 32'(bus.inst_pred_taken), 1);
`else
    chk("jal_next_addr", bus.icache_req_addr, 32'h104);
    chk("jal_pred", 32'(bus.inst_pred_taken), 0);
`endif
    auto_inst = 32'h13;
    do_reset();
    use_model = 1;
    rst_n = 1;
    repeat (3000) begin
      bus.icache_req_ready = $urandom_range(0, 3) != 0;
      bus.inst_ready = $urandom_range(0, 2) != 0;
      bus.redirect_valid = $urandom_range(0, 11) == 0;
      bus.redirect_pc = $urandom();
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
